cci_mpf_wro_event_stats: RTL and testbench

// Consumes the per-cycle t_cci_mpf_wro_pipe_events vector from the WRO pipeline and keeps one

---
 rtl/cci_mpf_csrs_pkg.sv | 25 ++
 rtl/cci_mpf_event_counter.sv | 48 ++++
 rtl/cci_mpf_wro_event_stats.sv | 64 ++++++
 tb/tb_cci_mpf_wro_event_stats.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_csrs_pkg.sv
// Shared MPF CSR types: WRO event vector layout and stats counter select.
package cci_mpf_csrs_pkg;

    localparam int CCI_MPF_WRO_NUM_EVENTS = 4;

    typedef enum logic [1:0] {
        RR = 2'd0,
        RW = 2'd1,
        WR = 2'd2,
        WW = 2'd3
    } t_cci_mpf_wro_event_idx;

    // rr is the MSB, so index RR selects events bit 3.
    typedef struct packed {
        logic rr_conflict;
        logic rw_conflict;
        logic wr_conflict;
        logic ww_conflict;
    } t_cci_mpf_wro_pipe_events;

    function automatic logic [1:0] evt_bit(input t_cci_mpf_wro_event_idx idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/cci_mpf_event_counter.sv
// Single event counter with optional saturation and a sticky overflow flag.
module cci_mpf_event_counter #(
    parameter int WIDTH    = 48,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             overflow
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    assign at_max = &value_q;

    // Clear takes priority so a coincident event is dropped.
    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (clear) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            ovf_d = ovf_q | at_max;
            if (!(at_max && SATURATE)) begin
                value_d = value_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value    = value_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/cci_mpf_wro_event_stats.sv
// WRO conflict statistics: four event counters behind a registered CSR read port.
module cci_mpf_wro_event_stats
    import cci_mpf_csrs_pkg::*;
#(
    parameter int COUNTER_WIDTH = 48,
    parameter bit SATURATE      = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              events_valid,
    input  t_cci_mpf_wro_pipe_events          events,
    input  logic                              clear,
    input  logic                              csr_rd_en,
    input  t_cci_mpf_wro_event_idx            csr_rd_idx,
    output logic                              csr_rd_valid,
    output logic [63:0]                       csr_rd_data,
    output logic [CCI_MPF_WRO_NUM_EVENTS-1:0] overflow
);

    logic [CCI_MPF_WRO_NUM_EVENTS-1:0] inc;
    logic [COUNTER_WIDTH-1:0]          cnt [CCI_MPF_WRO_NUM_EVENTS];

    assign inc = {CCI_MPF_WRO_NUM_EVENTS{events_valid}} & events;

    for (genvar i = 0; i < CCI_MPF_WRO_NUM_EVENTS; i++) begin : g_cnt
        cci_mpf_event_counter #(
            .WIDTH    (COUNTER_WIDTH),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .inc      (inc[i]),
            .value    (cnt[i]),
            .overflow (overflow[i])
        );
    end

    logic        rd_valid_q, rd_valid_d;
    logic [63:0] rd_data_q, rd_data_d;

    // Samples the pre-edge count, so same-cycle updates are not visible.
    always_comb begin
        rd_valid_d = csr_rd_en;
        rd_data_d  = rd_data_q;
        if (csr_rd_en) begin
            rd_data_d = 64'(cnt[evt_bit(csr_rd_idx)]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign csr_rd_valid = rd_valid_q;
    assign csr_rd_data  = rd_data_q;

endmodule

// File: tb/tb_cci_mpf_wro_event_stats.sv
// Scoreboard bench for cci_mpf_wro_event_stats: a 48-bit saturating instance
// plus 4-bit saturating and wrapping instances sharing one stimulus stream.
module tb_cci_mpf_wro_event_stats;
    import cci_mpf_csrs_pkg::*;

    typedef struct {
        logic [63:0] data;
        int          due;
        int          tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tag = 0;

    exp_t sb [3][$];

    // main instance
    logic                     ev_valid_m = 1'b0;
    t_cci_mpf_wro_pipe_events ev_m = '0;
    logic                     clr_m = 1'b0;
    logic                     rd_m = 1'b0;
    t_cci_mpf_wro_event_idx   idx_m = RR;
    logic                     rv_m;
    logic [63:0]              rdat_m;
    logic [3:0]               ovf_m;

    // small instances (shared inputs)
    logic                     ev_valid_s = 1'b0;
    t_cci_mpf_wro_pipe_events ev_s = '0;
    logic                     clr_s = 1'b0;
    logic                     rd_s = 1'b0;
    t_cci_mpf_wro_event_idx   idx_s = RR;
    logic                     rv_sat, rv_wrap;
    logic [63:0]              rdat_sat, rdat_wrap;
    logic [3:0]               ovf_sat, ovf_wrap;

    cci_mpf_wro_event_stats #(.COUNTER_WIDTH(48), .SATURATE(1'b1)) u_dut (
        .clk(clk), .reset(reset), .events_valid(ev_valid_m), .events(ev_m),
        .clear(clr_m), .csr_rd_en(rd_m), .csr_rd_idx(idx_m),
        .csr_rd_valid(rv_m), .csr_rd_data(rdat_m), .overflow(ovf_m));

    cci_mpf_wro_event_stats #(.COUNTER_WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .events_valid(ev_valid_s), .events(ev_s),
        .clear(clr_s), .csr_rd_en(rd_s), .csr_rd_idx(idx_s),
        .csr_rd_valid(rv_sat), .csr_rd_data(rdat_sat), .overflow(ovf_sat));

    cci_mpf_wro_event_stats #(.COUNTER_WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .events_valid(ev_valid_s), .events(ev_s),
        .clear(clr_s), .csr_rd_en(rd_s), .csr_rd_idx(idx_s),
        .csr_rd_valid(rv_wrap), .csr_rd_data(rdat_wrap), .overflow(ovf_wrap));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int d, input logic [63:0] data);
        exp_t e;
        e.data = data;
        e.due  = cyc + 1;
        e.tag  = tag;
        sb[d].push_back(e);
    endtask

    task automatic mon(input int d, input logic v, input logic [63:0] data);
        exp_t e;
        if (v) begin
            checks++;
            if (sb[d].size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd dut%0d got valid data=%0d required no read", d, data);
            end else begin
                e = sb[d].pop_front();
                if (e.due != cyc || e.data != data) begin
                    errors++;
                    $display("FAIL rd%0d dut%0d got data=%0d cyc=%0d required data=%0d cyc=%0d",
                             e.tag, d, data, cyc, e.data, e.due);
                end
            end
        end else if (sb[d].size() != 0 && sb[d][0].due <= cyc) begin
            checks++;
            errors++;
            e = sb[d].pop_front();
            $display("FAIL rd%0d dut%0d got no valid required data=%0d cyc=%0d",
                     e.tag, d, e.data, e.due);
        end
    endtask

    always @(negedge clk) begin
        mon(0, rv_m, rdat_m);
        mon(1, rv_sat, rdat_sat);
        mon(2, rv_wrap, rdat_wrap);
    end

    task automatic step_m(input logic v, input logic [3:0] e, input logic c,
                          input logic r, input int i, input logic [63:0] exp_d);
        @(negedge clk);
        ev_valid_m = v;
        ev_m       = e;
        clr_m      = c;
        rd_m       = r;
        idx_m      = t_cci_mpf_wro_event_idx'(i);
        if (r) begin
            tag++;
            push(0, exp_d);
        end
    endtask

    task automatic idle_m(input int n);
        repeat (n) step_m(1'b0, 4'b0, 1'b0, 1'b0, 0, 64'd0);
    endtask

    task automatic step_s(input logic v, input logic [3:0] e, input logic c,
                          input logic r, input int i,
                          input logic [63:0] exp_sat, input logic [63:0] exp_wrap);
        @(negedge clk);
        ev_valid_s = v;
        ev_s       = e;
        clr_s      = c;
        rd_s       = r;
        idx_s      = t_cci_mpf_wro_event_idx'(i);
        if (r) begin
            tag++;
            push(1, exp_sat);
            push(2, exp_wrap);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp4 [4];

        repeat (3) @(negedge clk);
        chk("reset_valid", {63'd0, rv_m}, 64'd0);
        chk("reset_data", rdat_m, 64'd0);
        chk("reset_ovf", {60'd0, ovf_m}, 64'd0);
        reset = 1'b0;

        // reads after reset, back-to-back
        for (int i = 0; i < 4; i++) step_m(1'b0, 4'b0, 1'b0, 1'b1, i, 64'd0);
        idle_m(2);

        // rr and wr each counted 10 times
        repeat (10) step_m(1'b1, 4'b1010, 1'b0, 1'b0, 0, 64'd0);
        idle_m(1);
        exp4 = '{64'd10, 64'd0, 64'd10, 64'd0};
        for (int i = 0; i < 4; i++) step_m(1'b0, 4'b0, 1'b0, 1'b1, i, exp4[i]);
        idle_m(2);
        chk("ovf_after_count", {60'd0, ovf_m}, 64'd0);

        // events ignored without events_valid
        repeat (5) step_m(1'b0, 4'b1111, 1'b0, 1'b0, 0, 64'd0);
        idle_m(1);
        for (int i = 0; i < 4; i++) step_m(1'b0, 4'b0, 1'b0, 1'b1, i, exp4[i]);
        idle_m(2);

        // ww to 7, then clear with a coincident ww event
        repeat (7) step_m(1'b1, 4'b0001, 1'b0, 1'b0, 0, 64'd0);
        step_m(1'b0, 4'b0, 1'b0, 1'b1, 3, 64'd7);
        step_m(1'b1, 4'b0001, 1'b1, 1'b0, 0, 64'd0);
        idle_m(1);
        for (int i = 0; i < 4; i++) step_m(1'b0, 4'b0, 1'b0, 1'b1, i, 64'd0);
        step_m(1'b1, 4'b0001, 1'b0, 1'b0, 0, 64'd0);
        idle_m(1);
        step_m(1'b0, 4'b0, 1'b0, 1'b1, 3, 64'd1);
        idle_m(2);

        // read coincident with an increment sees the old value
        repeat (3) step_m(1'b1, 4'b1000, 1'b0, 1'b0, 0, 64'd0);
        step_m(1'b1, 4'b1000, 1'b0, 1'b1, 0, 64'd3);
        step_m(1'b0, 4'b0, 1'b0, 1'b1, 0, 64'd4);
        idle_m(2);

        // reset during an issued read drops it
        step_m(1'b0, 4'b0, 1'b0, 1'b1, 0, 64'd0);
        sb[0].delete();
        tag--;
        reset = 1'b1;
        idle_m(1);
        chk("rst_midread_valid", {63'd0, rv_m}, 64'd0);
        chk("rst_midread_data", rdat_m, 64'd0);
        reset = 1'b0;
        idle_m(1);
        chk("rst_release_valid", {63'd0, rv_m}, 64'd0);
        step_m(1'b0, 4'b0, 1'b0, 1'b1, 0, 64'd0);
        idle_m(2);

        // 4-bit counters: 17 rr events, saturating vs wrapping
        repeat (17) step_s(1'b1, 4'b1000, 1'b0, 1'b0, 0, 64'd0, 64'd0);
        step_s(1'b0, 4'b0, 1'b0, 1'b1, 0, 64'd15, 64'd1);
        step_s(1'b0, 4'b0, 1'b0, 1'b1, 1, 64'd0, 64'd0);
        step_s(1'b0, 4'b0, 1'b0, 1'b0, 0, 64'd0, 64'd0);
        chk("sat_ovf", {60'd0, ovf_sat}, 64'h8);
        chk("wrap_ovf", {60'd0, ovf_wrap}, 64'h8);
        step_s(1'b0, 4'b0, 1'b1, 1'b0, 0, 64'd0, 64'd0);
        step_s(1'b0, 4'b0, 1'b0, 1'b0, 0, 64'd0, 64'd0);
        chk("sat_ovf_clear", {60'd0, ovf_sat}, 64'h0);
        chk("wrap_ovf_clear", {60'd0, ovf_wrap}, 64'h0);
        step_s(1'b0, 4'b0, 1'b0, 1'b1, 0, 64'd0, 64'd0);
        repeat (3) step_s(1'b0, 4'b0, 1'b0, 1'b0, 0, 64'd0, 64'd0);

        for (int d = 0; d < 3; d++) begin
            checks++;
            if (sb[d].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d got %0d pending reads required 0", d, sb[d].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
